// File: rtl/morse_tx_ctrl_if.sv
// Handshake bundle between the key/switch front end and the Morse sequencer.
// The abort signal exists only when MORSE_ABORT_EN is defined.
interface morse_tx_ctrl_if;
  logic       start;
  logic [2:0] letter;
`ifdef MORSE_ABORT_EN
  logic       abort;
`endif
  logic       led_out;
  logic       busy;
  logic       done;

`ifdef MORSE_ABORT_EN
  modport master (output start, letter, abort, input led_out, busy, done);
  modport slave  (input start, letter, abort, output led_out, busy, done);
`else
  modport master (output start, letter, input led_out, busy, done);
  modport slave  (input start, letter, output led_out, busy, done);
`endif
endinterface

// File: rtl/morse_tx_ctrl.sv
// Morse sequencer for letters A..H: table lookup, then mark/space timing on led_out.
// Optional feature: MORSE_ABORT_EN adds an abort input that drops a letter without done.
module morse_tx_ctrl #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  morse_tx_ctrl_if.slave   bus
);
  localparam int CW = $clog2(3 * TICK_DIV) + 1;
  localparam logic [CW-1:0] DOT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DASH_LAST = CW'(3 * TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, DONE} state_t;

  state_t        state_q;
  logic [3:0]    pat_q;
  logic [2:0]    len_q;
  logic [1:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic          led_q, busy_q, done_q;

  logic [3:0]    pat_d;
  logic [2:0]    len_d;
  logic [CW-1:0] mark_last;
  logic          last_elem;

  // Patterns are left-aligned so the current element is always pat_q[3] (1 = dash).
  always_comb begin
    pat_d = 4'b0000;
    len_d = 3'd1;
    case (bus.letter)
      3'd0: begin pat_d = 4'b0100; len_d = 3'd2; end
      3'd1: begin pat_d = 4'b1000; len_d = 3'd4; end
      3'd2: begin pat_d = 4'b1010; len_d = 3'd4; end
      3'd3: begin pat_d = 4'b1000; len_d = 3'd3; end
      3'd4: begin pat_d = 4'b0000; len_d = 3'd1; end
      3'd5: begin pat_d = 4'b0010; len_d = 3'd4; end
      3'd6: begin pat_d = 4'b1100; len_d = 3'd3; end
      3'd7: begin pat_d = 4'b0000; len_d = 3'd4; end
      default: begin pat_d = 4'b0000; len_d = 3'd1; end
    endcase
  end

  assign mark_last = pat_q[3] ? DASH_LAST : DOT_LAST;
  assign last_elem = ({1'b0, idx_q} == (len_q - 3'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end
`ifdef MORSE_ABORT_EN
    else if (bus.abort && (state_q != IDLE)) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end
`endif
    else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= '0;
            cnt_q   <= '0;
            led_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= MARK;
          end
        end
        MARK: begin
          if (cnt_q == mark_last) begin
            cnt_q   <= '0;
            led_q   <= 1'b0;
            state_q <= SPACE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SPACE: begin
          if (cnt_q == DOT_LAST) begin
            cnt_q <= '0;
            pat_q <= {pat_q[2:0], 1'b0};
            idx_q <= idx_q + 2'd1;
            if (last_elem) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              led_q   <= 1'b1;
              state_q <= MARK;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.led_out = led_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
